// File: rtl/pe_depacketizer_stream_pkg.sv
// Shared field layout and packet type definitions for the PE depacketizer.
// Layout from LSB: timestep, type bit, filter_row, payload (5 x FILTER_WIDTH).
package pe_depack_pkg;

  localparam int DEF_FILTER_WIDTH = 8;
  localparam int DEF_TS_W         = 1;
  localparam int DEF_ROW_W        = 3;
  localparam int DEF_NUM_ROWS     = 5;
  localparam int DEF_FIFO_DEPTH   = 2;
  localparam int DEF_ERR_W        = 8;

  typedef enum logic {
    PKT_IFMAP  = 1'b0,
    PKT_FILTER = 1'b1
  } pkt_type_e;

  function automatic int data_w(input int filter_width);
    return 5 * filter_width;
  endfunction

  function automatic int type_bit(input int ts_w);
    return ts_w;
  endfunction

  function automatic int row_lsb(input int ts_w);
    return ts_w + 1;
  endfunction

  function automatic int data_lsb(input int ts_w, input int row_w);
    return ts_w + 1 + row_w;
  endfunction

  function automatic int pkt_w(input int filter_width, input int ts_w, input int row_w);
    return data_w(filter_width) + row_w + 1 + ts_w;
  endfunction

  localparam int DEF_DATA_W   = data_w(DEF_FILTER_WIDTH);
  localparam int DEF_TYPE_BIT = type_bit(DEF_TS_W);
  localparam int DEF_ROW_LSB  = row_lsb(DEF_TS_W);
  localparam int DEF_DATA_LSB = data_lsb(DEF_TS_W, DEF_ROW_W);
  localparam int DEF_PKT_W    = pkt_w(DEF_FILTER_WIDTH, DEF_TS_W, DEF_ROW_W);

endpackage

// File: rtl/pe_depacketizer_stream_if.sv
// Packet input, filter/ifmap output streams and error status of the depacketizer.
interface pe_depacketizer_stream_if
  import pe_depack_pkg::*;
#(
  parameter int FILTER_WIDTH = DEF_FILTER_WIDTH,
  parameter int TS_W         = DEF_TS_W,
  parameter int ROW_W        = DEF_ROW_W,
  parameter int ERR_W        = DEF_ERR_W
);
  localparam int DATA_W = data_w(FILTER_WIDTH);
  localparam int PKT_W  = pkt_w(FILTER_WIDTH, TS_W, ROW_W);

  logic              pkt_valid;
  logic              pkt_ready;
  logic [PKT_W-1:0]  pkt_data;

  logic              flt_valid;
  logic              flt_ready;
  logic [ROW_W-1:0]  flt_row;
  logic [DATA_W-1:0] flt_data;
  logic              flt_last;

  logic              ifm_valid;
  logic              ifm_ready;
  logic [ROW_W-1:0]  ifm_row;
  logic [TS_W-1:0]   ifm_ts;
  logic [DATA_W-1:0] ifm_data;
  logic              ifm_ts_new;

  logic              row_err;
  logic              seq_err;
  logic [ERR_W-1:0]  err_count;

  modport slave (
    input  pkt_valid, pkt_data, flt_ready, ifm_ready,
    output pkt_ready,
    output flt_valid, flt_row, flt_data, flt_last,
    output ifm_valid, ifm_row, ifm_ts, ifm_data, ifm_ts_new,
    output row_err, seq_err, err_count
  );

  modport master (
    output pkt_valid, pkt_data, flt_ready, ifm_ready,
    input  pkt_ready,
    input  flt_valid, flt_row, flt_data, flt_last,
    input  ifm_valid, ifm_row, ifm_ts, ifm_data, ifm_ts_new,
    input  row_err, seq_err, err_count
  );

endinterface

// File: rtl/pe_depacketizer_stream_fifo.sv
// Small synchronous FIFO; outputs come straight from the storage registers.
module pe_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pe_depacketizer_stream.sv
// Decodes PE-bound packets and steers them into buffered filter and ifmap streams,
// checking filter row order, marking the last row and flagging ifmap timestep changes.
module pe_depacketizer_stream
  import pe_depack_pkg::*;
#(
  parameter int FILTER_WIDTH = DEF_FILTER_WIDTH,
  parameter int TS_W         = DEF_TS_W,
  parameter int ROW_W        = DEF_ROW_W,
  parameter int NUM_ROWS     = DEF_NUM_ROWS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int ERR_W        = DEF_ERR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  pe_depacketizer_stream_if.slave  bus
);
  localparam int DATA_W   = data_w(FILTER_WIDTH);
  localparam int TYPE_BIT = type_bit(TS_W);
  localparam int ROW_LSB  = row_lsb(TS_W);
  localparam int DATA_LSB = data_lsb(TS_W, ROW_W);
  localparam int FLT_W    = 1 + ROW_W + DATA_W;
  localparam int IFM_W    = 1 + TS_W + ROW_W + DATA_W;

  logic [TS_W-1:0]   pkt_ts;
  logic [ROW_W-1:0]  pkt_row;
  logic [DATA_W-1:0] pkt_payload;
  pkt_type_e         pkt_type;
  logic              row_bad, accept, flt_push, ifm_push, flt_last_in, ts_new_in;
  logic              flt_full, flt_empty, flt_pop, ifm_full, ifm_empty, ifm_pop;
  logic [FLT_W-1:0]  flt_din, flt_dout;
  logic [IFM_W-1:0]  ifm_din, ifm_dout;

  logic [ROW_W-1:0]  exp_row_q, exp_row_d;
  logic [TS_W-1:0]   last_ts_q, last_ts_d;
  logic              first_q, first_d;
  logic              row_err_q, row_err_d;
  logic              seq_err_q, seq_err_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  always_comb begin
    pkt_ts      = bus.pkt_data[0 +: TS_W];
    pkt_type    = pkt_type_e'(bus.pkt_data[TYPE_BIT]);
    pkt_row     = bus.pkt_data[ROW_LSB +: ROW_W];
    pkt_payload = bus.pkt_data[DATA_LSB +: DATA_W];
    row_bad     = ({1'b0, pkt_row} >= (ROW_W + 1)'(NUM_ROWS));
    flt_last_in = (pkt_row == ROW_W'(NUM_ROWS - 1));
    ts_new_in   = first_q || (pkt_ts != last_ts_q);

    // Bad rows are always swallowed; good ones wait for room (a full FIFO never bypasses).
    if (rst)                        bus.pkt_ready = 1'b0;
    else if (row_bad)               bus.pkt_ready = 1'b1;
    else if (pkt_type == PKT_FILTER) bus.pkt_ready = !flt_full;
    else                            bus.pkt_ready = !ifm_full;

    accept   = bus.pkt_valid && bus.pkt_ready;
    flt_push = accept && !row_bad && (pkt_type == PKT_FILTER);
    ifm_push = accept && !row_bad && (pkt_type == PKT_IFMAP);
    flt_din  = {flt_last_in, pkt_row, pkt_payload};
    ifm_din  = {ts_new_in, pkt_ts, pkt_row, pkt_payload};
  end

  always_comb begin
    exp_row_d   = exp_row_q;
    last_ts_d   = last_ts_q;
    first_d     = first_q;
    row_err_d   = accept && row_bad;
    seq_err_d   = flt_push && (pkt_row != exp_row_q);
    err_count_d = err_count_q;
    if (flt_push) exp_row_d = flt_last_in ? '0 : pkt_row + ROW_W'(1);
    if (ifm_push) begin
      last_ts_d = pkt_ts;
      first_d   = 1'b0;
    end
    if ((row_err_d || seq_err_d) && (err_count_q != '1))
      err_count_d = err_count_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_row_q   <= '0;
      last_ts_q   <= '0;
      first_q     <= 1'b1;
      row_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      exp_row_q   <= exp_row_d;
      last_ts_q   <= last_ts_d;
      first_q     <= first_d;
      row_err_q   <= row_err_d;
      seq_err_q   <= seq_err_d;
      err_count_q <= err_count_d;
    end
  end

  pe_sync_fifo #(.WIDTH(FLT_W), .DEPTH(FIFO_DEPTH)) u_flt_fifo (
    .clk(clk), .rst(rst),
    .push(flt_push), .din(flt_din), .full(flt_full),
    .pop(flt_pop), .dout(flt_dout), .empty(flt_empty)
  );

  pe_sync_fifo #(.WIDTH(IFM_W), .DEPTH(FIFO_DEPTH)) u_ifm_fifo (
    .clk(clk), .rst(rst),
    .push(ifm_push), .din(ifm_din), .full(ifm_full),
    .pop(ifm_pop), .dout(ifm_dout), .empty(ifm_empty)
  );

  assign bus.flt_valid = !flt_empty;
  assign flt_pop       = bus.flt_valid && bus.flt_ready;
  assign {bus.flt_last, bus.flt_row, bus.flt_data} = flt_dout;

  assign bus.ifm_valid = !ifm_empty;
  assign ifm_pop       = bus.ifm_valid && bus.ifm_ready;
  assign {bus.ifm_ts_new, bus.ifm_ts, bus.ifm_row, bus.ifm_data} = ifm_dout;

  assign bus.row_err   = row_err_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_pe_depacketizer_stream.sv
// Directed self-checking bench for pe_depacketizer_stream with default parameters.
module tb_pe_depacketizer_stream;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  pe_depacketizer_stream_if #(.FILTER_WIDTH(8), .TS_W(1), .ROW_W(3), .ERR_W(8)) bus ();

  pe_depacketizer_stream #(
    .FILTER_WIDTH(8), .TS_W(1), .ROW_W(3), .NUM_ROWS(5), .FIFO_DEPTH(2), .ERR_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packet layout: {payload[39:0], row[2:0], type, ts}
  function automatic logic [44:0] make_pkt(input logic typ, input logic [2:0] row,
                                           input logic ts, input logic [39:0] d);
    return {d, row, typ, ts};
  endfunction

  task automatic drive(input logic typ, input logic [2:0] row, input logic ts, input logic [39:0] d);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = make_pkt(typ, row, ts, d);
    #1;
  endtask

  task automatic idle();
    bus.pkt_valid = 1'b0;
    bus.pkt_data  = '0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flt_ready = 1'b1;
    bus.ifm_ready = 1'b1;
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = make_pkt(1'b1, 3'd0, 1'b0, 40'h1);
    #1;
    n_checks++;
    if (bus.pkt_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pkt_ready: got %b want 0", bus.pkt_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    n_checks++;
    if (bus.flt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flt_valid: got %b want 0", bus.flt_valid); end
    n_checks++;
    if (bus.ifm_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ifm_valid: got %b want 0", bus.ifm_valid); end
    n_checks++;
    if ({bus.row_err, bus.seq_err} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_err_pulses: got %b want 00", {bus.row_err, bus.seq_err}); end
    n_checks++;
    if (bus.err_count !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_err_count: got %0d want 0", bus.err_count); end
  endtask

  task automatic test_single_filter();
    do_reset();
    drive(1'b1, 3'd0, 1'b0, 40'h0123456789);
    n_checks++;
    if (bus.pkt_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_pkt_ready: got %b want 1", bus.pkt_ready); end
    @(negedge clk);
    idle();
    n_checks++;
    if (bus.flt_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_flt_valid: got %b want 1", bus.flt_valid); end
    n_checks++;
    if (bus.flt_row !== 3'd0) begin n_fail++; $display("[TB] FAIL single_flt_row: got %0d want 0", bus.flt_row); end
    n_checks++;
    if (bus.flt_data !== 40'h0123456789) begin n_fail++; $display("[TB] FAIL single_flt_data: got %h want 0123456789", bus.flt_data); end
    n_checks++;
    if (bus.flt_last !== 1'b0) begin n_fail++; $display("[TB] FAIL single_flt_last: got %b want 0", bus.flt_last); end
    n_checks++;
    if (bus.seq_err !== 1'b0) begin n_fail++; $display("[TB] FAIL single_seq_err: got %b want 0", bus.seq_err); end
    n_checks++;
    if (bus.ifm_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ifm_valid: got %b want 0", bus.ifm_valid); end
    @(negedge clk);
    n_checks++;
    if (bus.flt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_popped: got %b want 0", bus.flt_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.flt_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin
        n_checks++;
        if (bus.flt_valid !== 1'b1 || bus.flt_row !== 3'(i - 1) || bus.flt_data !== (40'hAB00000000 | 40'(i - 1)))
          begin n_fail++; $display("[TB] FAIL b2b_out_%0d: got v=%b row=%0d data=%h want v=1 row=%0d", i - 1, bus.flt_valid, bus.flt_row, bus.flt_data, i - 1); end
        n_checks++;
        if (bus.flt_last !== (i == 5)) begin n_fail++; $display("[TB] FAIL b2b_last_%0d: got %b want %b", i - 1, bus.flt_last, (i == 5)); end
        n_checks++;
        if (bus.seq_err !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_seq_err_%0d: got %b want 0", i - 1, bus.seq_err); end
      end
      if (i < 5) begin
        drive(1'b1, 3'(i), 1'b0, 40'hAB00000000 | 40'(i));
        n_checks++;
        if (bus.pkt_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready_%0d: got %b want 1", i, bus.pkt_ready); end
      end else begin
        idle();
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.err_count !== 8'd0) begin n_fail++; $display("[TB] FAIL b2b_err_count: got %0d want 0", bus.err_count); end
  endtask

  task automatic test_seq_error();
    do_reset();
    bus.flt_ready = 1'b1;
    drive(1'b1, 3'd0, 1'b0, 40'h1);
    @(negedge clk);
    drive(1'b1, 3'd2, 1'b0, 40'h2);
    n_checks++;
    if (bus.seq_err !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_row0_no_err: got %b want 0", bus.seq_err); end
    @(negedge clk);
    drive(1'b1, 3'd3, 1'b0, 40'h3);
    n_checks++;
    if (bus.seq_err !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_err_pulse: got %b want 1", bus.seq_err); end
    n_checks++;
    if (bus.err_count !== 8'd1) begin n_fail++; $display("[TB] FAIL seq_err_count: got %0d want 1", bus.err_count); end
    n_checks++;
    if (bus.flt_valid !== 1'b1 || bus.flt_row !== 3'd2) begin n_fail++; $display("[TB] FAIL seq_fwd_row2: got v=%b row=%0d want v=1 row=2", bus.flt_valid, bus.flt_row); end
    @(negedge clk);
    idle();
    n_checks++;
    if (bus.seq_err !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_row3_no_err: got %b want 0", bus.seq_err); end
    n_checks++;
    if (bus.flt_valid !== 1'b1 || bus.flt_row !== 3'd3) begin n_fail++; $display("[TB] FAIL seq_fwd_row3: got v=%b row=%0d want v=1 row=3", bus.flt_valid, bus.flt_row); end
    @(negedge clk);
    n_checks++;
    if (bus.err_count !== 8'd1) begin n_fail++; $display("[TB] FAIL seq_err_count_final: got %0d want 1", bus.err_count); end
  endtask

  task automatic test_bad_row();
    do_reset();
    bus.flt_ready = 1'b1;
    bus.ifm_ready = 1'b1;
    drive(1'b0, 3'd6, 1'b1, 40'hDEADBEEF00);
    n_checks++;
    if (bus.pkt_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_row_ready: got %b want 1", bus.pkt_ready); end
    @(negedge clk);
    idle();
    n_checks++;
    if (bus.row_err !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_row_pulse: got %b want 1", bus.row_err); end
    n_checks++;
    if (bus.err_count !== 8'd1) begin n_fail++; $display("[TB] FAIL bad_row_count: got %0d want 1", bus.err_count); end
    n_checks++;
    if ({bus.flt_valid, bus.ifm_valid, bus.seq_err} !== 3'b000) begin n_fail++; $display("[TB] FAIL bad_row_dropped: got flt=%b ifm=%b seq=%b want 000", bus.flt_valid, bus.ifm_valid, bus.seq_err); end
    // A dropped row must leave the expected filter row at 0.
    drive(1'b1, 3'd0, 1'b0, 40'h5);
    @(negedge clk);
    idle();
    n_checks++;
    if (bus.row_err !== 1'b0) begin n_fail++; $display("[TB] FAIL bad_row_pulse_end: got %b want 0", bus.row_err); end
    n_checks++;
    if (bus.seq_err !== 1'b0 || bus.flt_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_row_keeps_expected: got seq=%b v=%b want seq=0 v=1", bus.seq_err, bus.flt_valid); end
    n_checks++;
    if (bus.err_count !== 8'd1) begin n_fail++; $display("[TB] FAIL bad_row_count_hold: got %0d want 1", bus.err_count); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.flt_ready = 1'b1;
    bus.ifm_ready = 1'b0;
    drive(1'b0, 3'd1, 1'b0, 40'hA1);
    n_checks++;
    if (bus.pkt_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_1: got %b want 1", bus.pkt_ready); end
    @(negedge clk);
    drive(1'b0, 3'd2, 1'b0, 40'hA2);
    n_checks++;
    if (bus.pkt_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_2: got %b want 1", bus.pkt_ready); end
    @(negedge clk);
    drive(1'b0, 3'd3, 1'b1, 40'hA3);
    n_checks++;
    if (bus.pkt_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_full: got %b want 0", bus.pkt_ready); end
    @(negedge clk);
    drive(1'b1, 3'd0, 1'b0, 40'hF0);
    n_checks++;
    if (bus.pkt_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_flt_ready: got %b want 1", bus.pkt_ready); end
    n_checks++;
    if (bus.ifm_valid !== 1'b1 || bus.ifm_row !== 3'd1 || bus.ifm_ts_new !== 1'b1 || bus.ifm_data !== 40'hA1)
      begin n_fail++; $display("[TB] FAIL bp_ifm_head_held: got v=%b row=%0d new=%b data=%h want v=1 row=1 new=1 data=a1", bus.ifm_valid, bus.ifm_row, bus.ifm_ts_new, bus.ifm_data); end
    @(negedge clk);
    n_checks++;
    if (bus.flt_valid !== 1'b1 || bus.flt_row !== 3'd0 || bus.flt_data !== 40'hF0 || bus.flt_last !== 1'b0)
      begin n_fail++; $display("[TB] FAIL bp_flt_delivered: got v=%b row=%0d data=%h last=%b want v=1 row=0 data=f0 last=0", bus.flt_valid, bus.flt_row, bus.flt_data, bus.flt_last); end
    // Releasing ready in the same cycle must not let the third ifmap packet in yet.
    bus.ifm_ready = 1'b1;
    drive(1'b0, 3'd3, 1'b1, 40'hA3);
    n_checks++;
    if (bus.pkt_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_no_bypass: got %b want 0", bus.pkt_ready); end
    @(negedge clk);
    n_checks++;
    if (bus.ifm_valid !== 1'b1 || bus.ifm_row !== 3'd2 || bus.ifm_ts !== 1'b0 || bus.ifm_ts_new !== 1'b0)
      begin n_fail++; $display("[TB] FAIL bp_ifm_second: got v=%b row=%0d ts=%b new=%b want v=1 row=2 ts=0 new=0", bus.ifm_valid, bus.ifm_row, bus.ifm_ts, bus.ifm_ts_new); end
    n_checks++;
    if (bus.pkt_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_after_pop: got %b want 1", bus.pkt_ready); end
    @(negedge clk);
    idle();
    n_checks++;
    if (bus.ifm_valid !== 1'b1 || bus.ifm_row !== 3'd3 || bus.ifm_ts !== 1'b1 || bus.ifm_ts_new !== 1'b1 || bus.ifm_data !== 40'hA3)
      begin n_fail++; $display("[TB] FAIL bp_ifm_third: got v=%b row=%0d ts=%b new=%b data=%h want v=1 row=3 ts=1 new=1 data=a3", bus.ifm_valid, bus.ifm_row, bus.ifm_ts, bus.ifm_ts_new, bus.ifm_data); end
    @(negedge clk);
    n_checks++;
    if (bus.ifm_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ifm_drained: got %b want 0", bus.ifm_valid); end
  endtask

  task automatic test_err_saturation();
    do_reset();
    drive(1'b1, 3'd7, 1'b0, 40'h0);
    repeat (260) @(negedge clk);
    n_checks++;
    if (bus.err_count !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_count: got %0d want 255", bus.err_count); end
    n_checks++;
    if (bus.row_err !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_row_err: got %b want 1", bus.row_err); end
    idle();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.err_count !== 8'd255 || bus.row_err !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_hold: got count=%0d row_err=%b want 255 0", bus.err_count, bus.row_err); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bus.flt_ready = 1'b0;
    bus.ifm_ready = 1'b0;
    drive(1'b1, 3'd0, 1'b0, 40'h10);
    @(negedge clk);
    drive(1'b1, 3'd3, 1'b0, 40'h11);
    @(negedge clk);
    drive(1'b0, 3'd0, 1'b1, 40'h12);
    @(negedge clk);
    drive(1'b0, 3'd1, 1'b1, 40'h13);
    @(negedge clk);
    drive(1'b1, 3'd2, 1'b0, 40'h14);
    n_checks++;
    if (bus.pkt_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_flt_full: got %b want 0", bus.pkt_ready); end
    drive(1'b0, 3'd2, 1'b1, 40'h15);
    n_checks++;
    if (bus.pkt_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_ifm_full: got %b want 0", bus.pkt_ready); end
    n_checks++;
    if (bus.err_count !== 8'd1 || bus.flt_valid !== 1'b1 || bus.ifm_valid !== 1'b1)
      begin n_fail++; $display("[TB] FAIL mid_pre_reset: got count=%0d flt=%b ifm=%b want 1 1 1", bus.err_count, bus.flt_valid, bus.ifm_valid); end
    rst = 1'b1;
    drive(1'b0, 3'd0, 1'b1, 40'h16);
    n_checks++;
    if (bus.pkt_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_ready_in_rst: got %b want 0", bus.pkt_ready); end
    @(negedge clk);
    rst = 1'b0;
    idle();
    n_checks++;
    if (bus.flt_valid !== 1'b0 || bus.ifm_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_valids_cleared: got flt=%b ifm=%b want 0 0", bus.flt_valid, bus.ifm_valid); end
    n_checks++;
    if (bus.err_count !== 8'd0) begin n_fail++; $display("[TB] FAIL mid_err_cleared: got %0d want 0", bus.err_count); end
    bus.ifm_ready = 1'b1;
    drive(1'b0, 3'd4, 1'b1, 40'h17);
    @(negedge clk);
    idle();
    n_checks++;
    if (bus.ifm_valid !== 1'b1 || bus.ifm_ts_new !== 1'b1 || bus.ifm_ts !== 1'b1 || bus.ifm_row !== 3'd4 || bus.ifm_data !== 40'h17)
      begin n_fail++; $display("[TB] FAIL mid_first_ts_new: got v=%b new=%b ts=%b row=%0d data=%h want 1 1 1 4 17", bus.ifm_valid, bus.ifm_ts_new, bus.ifm_ts, bus.ifm_row, bus.ifm_data); end
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.pkt_data  = '0;
    bus.flt_ready = 1'b0;
    bus.ifm_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_filter();
    test_back_to_back();
    test_seq_error();
    test_bad_row();
    test_backpressure();
    test_err_saturation();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
